// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and 8N1 frame constants.
package uart_pkg;

  // Default oversampling: 3.6864 MHz system clock / 115200 baud.
  localparam int CLKS_PER_BIT_DEF = 32;

  // 8N1 frame: one start bit, eight data bits, one stop bit.
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = DATA_BITS + 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. The head entry is always presented on
// pop_data_o; a push while full is accepted only when a pop frees a slot in
// the same cycle. Storage is not reset; pop_data_o reads 0 while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [$clog2(DEPTH):0]     count_next_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == COUNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // A pop on an empty FIFO is ignored; a full FIFO still accepts a push
  // when the same cycle pops the head.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointers and fill level; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and fill-level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; no reset needed since reads are gated by empty_o.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o   = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a show-ahead FIFO, with sticky frame/overrun
// flags and an RTS flow-control output that holds the host off once the
// FIFO reaches RTS_THRESH entries.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DEPTH        = 16,
  parameter int RTS_THRESH   = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx,
  output logic                    rts,
  output logic [7:0]              rd_data,
  output logic                    rd_valid,
  input  logic                    rd_pop,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    frame_err,
  output logic                    overrun,
  input  logic                    err_clr,
  output rx_state_e               dbg_state
);

  localparam int COUNT_W = $clog2(DEPTH) + 1;
  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  // Handshake: rd_valid means the FIFO head is on rd_data; a cycle with
  // rd_pop=1 and rd_valid=1 consumes exactly that byte at the next edge,
  // and rd_pop with rd_valid=0 has no effect.

  logic              rx_meta_q, rx_s;
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              rx_push, ferr_set, ovr_set;
  logic              frame_err_q, overrun_q, rts_q;
  logic              fifo_full, fifo_empty;
  logic [COUNT_W-1:0] count_next;

  // Two-flop synchronizer for the asynchronous serial input, idling high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  // Receiver state and bit-timing registers; reset drops any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic: confirm the start bit at mid-bit, then sample each
  // following bit one full bit period later.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        // A held-low line (break) must go high before a new frame may start.
        clk_cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: push or flag a framing error on the stop-sample cycle.
  always_comb begin
    rx_push  = 1'b0;
    ferr_set = 1'b0;
    if (state_q == ST_STOP && clk_cnt_q == BIT_LAST) begin
      rx_push  = rx_s;
      ferr_set = !rx_s;
    end
  end

  // A push is dropped only when the FIFO is full and nothing pops this cycle.
  assign ovr_set = rx_push && fifo_full && !rd_pop;

  // Sticky error flags; a same-cycle set beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (ferr_set)     frame_err_q <= 1'b1;
      else if (err_clr) frame_err_q <= 1'b0;
      if (ovr_set)      overrun_q   <= 1'b1;
      else if (err_clr) overrun_q   <= 1'b0;
    end
  end

  // Registered flow control from the fill level the FIFO is moving to, so
  // RTS rises on the same edge the threshold is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rts_q <= 1'b1;
    else        rts_q <= (count_next >= COUNT_W'(RTS_THRESH));
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (rx_push),
    .push_data_i  (shift_q),
    .pop_i        (rd_pop),
    .pop_data_o   (rd_data),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (count),
    .count_next_o (count_next)
  );

  assign rd_valid  = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rts       = rts_q;
  assign dbg_state = state_q;

endmodule
